// File: rtl/cpu_boot_ctrl.sv
// Program loader and run controller for the single-cycle RISC-V core.
// Streams a little-endian word image into imem, then runs the core until ebreak or timeout.
module cpu_boot_ctrl #(
    parameter int IMEM_WORDS = 512,
    parameter int ADDR_W     = 9,
    parameter int TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    input  logic              run_again,
    output logic              cpu_reset,
    input  logic [31:0]       cpu_instr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [31:0]       run_cycles,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic [31:0] EBREAK       = 32'h0010_0073;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [16:0] MAX_COUNT    = 17'(IMEM_WORDS);

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [15:0]         word_idx_q, word_idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         word_q, word_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic [31:0]         run_cycles_q, run_cycles_d;
    logic                byte_acc;

    assign rx_ready  = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_LOAD);
    assign byte_acc  = rx_valid && rx_ready;
    assign cpu_reset = (state_q != S_RUN);
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign run_cycles = run_cycles_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        lane_d       = lane_q;
        word_d       = word_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        run_cycles_d = run_cycles_q;

        case (state_q)
            S_HDR0: begin
                if (byte_acc) begin
                    count_d = {count_q[15:8], rx_data};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (byte_acc) begin
                    count_d = {rx_data, count_q[7:0]};
                    if ((count_d == 16'd0) || ({1'b0, count_d} > MAX_COUNT)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_LOAD;
                        word_idx_d = 16'd0;
                        lane_d     = 2'd0;
                    end
                end
            end
            S_LOAD: begin
                // Leave only once the final write is on the port, so the
                // core's first fetch sees fully written memory.
                if (imem_we_q && (word_idx_q == count_q)) begin
                    state_d      = S_RUN;
                    run_cycles_d = 32'd0;
                end else if (byte_acc) begin
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q[ADDR_W-1:0];
                            imem_wdata_d = {rx_data, word_q};
                            word_idx_d   = word_idx_q + 16'd1;
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end
            S_RUN: begin
                run_cycles_d = run_cycles_q + 32'd1;
                if (cpu_instr == EBREAK) begin
                    state_d = S_DONE;
                end else if (run_cycles_q == TIMEOUT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (run_again) begin
                    state_d      = S_RUN;
                    run_cycles_d = 32'd0;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_HDR0;
            end
        endcase

        // reload beats everything, including a write that would issue this cycle.
        if (reload) begin
            state_d      = S_HDR0;
            imem_we_d    = 1'b0;
            imem_addr_d  = imem_addr_q;
            imem_wdata_d = imem_wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_HDR0;
            count_q      <= 16'd0;
            word_idx_q   <= 16'd0;
            lane_q       <= 2'd0;
            word_q       <= 24'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            run_cycles_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            run_cycles_q <= run_cycles_d;
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: header vector table, directed load/run sequences,
// and random programs checked against an instruction-walking reference model.
module tb_cpu_boot_ctrl;

    localparam int IMEM_WORDS = 512;
    localparam int ADDR_W     = 9;
    localparam int TIMEOUT    = 16;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] SELF_LOOP = 32'h0000_006F;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              reload = 1'b0;
    logic              run_again = 1'b0;
    logic              cpu_reset;
    logic [31:0]       cpu_instr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       run_cycles;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .IMEM_WORDS(IMEM_WORDS),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .run_again (run_again),
        .cpu_reset (cpu_reset),
        .cpu_instr (cpu_instr),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .run_cycles(run_cycles),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Environment: synchronous imem and a fetch-only core (jal x0,0 holds the PC).
    logic [31:0]       mem [0:IMEM_WORDS-1];
    logic [ADDR_W-1:0] pc = '0;
    assign cpu_instr = mem[pc];

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (cpu_reset) pc <= '0;
        else if (cpu_instr != SELF_LOOP) pc <= pc + 1'b1;
    end

    // Scoreboard
    int vec_cnt = 0;
    int err_cnt = 0;
    int we_pulses = 0;
    int low_cycles = 0;
    logic we_prev = 1'b0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] exp_w;
    logic [31:0] ref_mem [0:IMEM_WORDS-1];

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) ref_mem[i] = 32'h0;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            we_pulses++;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL imem_write: got unexpected addr=%0h data=%h", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== exp_w) begin
                    err_cnt++;
                    $display("FAIL imem_write: got addr=%0h data=%h, expected addr=%0h data=%h",
                             imem_addr, imem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
                end
            end
            if (we_prev) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL imem_we_width: got 2+ cycle pulse, expected 1 cycle");
            end
        end
        we_prev = imem_we;
        if (!cpu_reset) low_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic load_program(input logic [31:0] words[$], input int max_gap);
        logic [15:0] n;
        n = 16'(words.size());
        low_cycles = 0;
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back({ADDR_W'(i), words[i]});
            ref_mem[i] = words[i];
            send_word(words[i], max_gap);
        end
    endtask

    // Reference: fetch from the intended memory image until ebreak or TIMEOUT fetches.
    task automatic predict(output bit halts, output int cycles);
        int p;
        logic [31:0] instr;
        p = 0;
        cycles = 0;
        halts = 1'b0;
        forever begin
            cycles++;
            instr = ref_mem[p];
            if (instr == EBREAK) begin
                halts = 1'b1;
                return;
            end
            if (cycles == TIMEOUT) return;
            if (instr != SELF_LOOP) p++;
        end
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || error) && n < 500) begin
            tick();
            n++;
        end
        check({name, "_end_reached"}, 32'(n < 500), 32'd1);
    endtask

    task automatic run_and_check(input string name);
        bit halts;
        int cyc;
        wait_end(name);
        predict(halts, cyc);
        check({name, "_done"}, 32'(done), 32'(halts));
        check({name, "_error"}, 32'(error), 32'(!halts));
        check({name, "_run_cycles"}, run_cycles, 32'(cyc));
        check({name, "_cpu_reset_low"}, 32'(low_cycles), 32'(cyc));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_flags"}, {26'd0, rx_ready, cpu_reset, busy, done, error, imem_we}, 32'b110000);
        check({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_imem_wdata"}, imem_wdata, 32'd0);
        check({name, "_run_cycles"}, run_cycles, 32'd0);
    endtask

    typedef struct {
        logic       rx_valid;
        logic [7:0] rx_data;
        logic       reload;
        logic [5:0] exp;  // {rx_ready, cpu_reset, busy, done, error, imem_we}
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rl, input logic [5:0] e);
        vec_t r;
        r.rx_valid = v;
        r.rx_data  = d;
        r.reload   = rl;
        r.exp      = e;
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t hdr_vec[11];
        logic [31:0] prog3[$];
        logic [31:0] words[$];
        int snap;

        prog3 = '{32'h0050_0513, 32'h0030_0593, EBREAK};

        hdr_vec[0]  = mk(1'b1, 8'h00, 1'b0, 6'b110000); // HDR1
        hdr_vec[1]  = mk(1'b1, 8'h00, 1'b0, 6'b010010); // count=0 -> ERR
        hdr_vec[2]  = mk(1'b1, 8'h55, 1'b0, 6'b010010); // ignored in ERR
        hdr_vec[3]  = mk(1'b0, 8'h00, 1'b1, 6'b110000); // reload -> HDR0
        hdr_vec[4]  = mk(1'b1, 8'h01, 1'b0, 6'b110000);
        hdr_vec[5]  = mk(1'b1, 8'h02, 1'b0, 6'b010010); // count=513 -> ERR
        hdr_vec[6]  = mk(1'b0, 8'h00, 1'b0, 6'b010010);
        hdr_vec[7]  = mk(1'b0, 8'h00, 1'b1, 6'b110000);
        hdr_vec[8]  = mk(1'b1, 8'h00, 1'b0, 6'b110000);
        hdr_vec[9]  = mk(1'b1, 8'h02, 1'b0, 6'b111000); // count=512 -> LOAD
        hdr_vec[10] = mk(1'b0, 8'h00, 1'b1, 6'b110000);

        // Reset
        reset = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        reset = 1'b1;

        // Header vectors
        for (int i = 0; i < 11; i++) begin
            rx_valid = hdr_vec[i].rx_valid;
            rx_data  = hdr_vec[i].rx_data;
            reload   = hdr_vec[i].reload;
            tick();
            rx_valid = 1'b0;
            reload   = 1'b0;
            check($sformatf("hdr_vec_%0d", i),
                  {26'd0, rx_ready, cpu_reset, busy, done, error, imem_we}, 32'(hdr_vec[i].exp));
        end
        check("hdr_no_write", 32'(we_pulses), 32'd0);

        // Three-word program, back-to-back bytes
        snap = we_pulses;
        load_program(prog3, 0);
        run_and_check("prog3");
        check("prog3_we_pulses", 32'(we_pulses - snap), 32'd3);

        // Re-run from DONE
        snap = we_pulses;
        low_cycles = 0;
        run_again = 1'b1;
        tick();
        run_again = 1'b0;
        check("rerun_enter", {30'd0, busy, cpu_reset}, 32'b10);
        tick();
        check("rerun_first_count", run_cycles, 32'd1);
        run_and_check("rerun");
        check("rerun_no_write", 32'(we_pulses - snap), 32'd0);

        // reload and run_again together
        reload = 1'b1;
        run_again = 1'b1;
        tick();
        reload = 1'b0;
        run_again = 1'b0;
        check("reload_wins", {28'd0, rx_ready, cpu_reset, busy, done}, 32'b1100);

        // Timeout on a self-loop
        words = '{SELF_LOOP};
        load_program(words, 0);
        run_and_check("timeout");
        check("timeout_count", run_cycles, 32'(TIMEOUT));
        pulse_reload();

        // Gapped byte stream
        snap = we_pulses;
        load_program(prog3, 5);
        run_and_check("gaps");
        check("gaps_we_pulses", 32'(we_pulses - snap), 32'd3);
        pulse_reload();

        // Reset mid-word 1
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({ADDR_W'(0), prog3[0]});
        ref_mem[0] = prog3[0];
        send_word(prog3[0], 0);
        send_byte(prog3[1][7:0], 0);
        send_byte(prog3[1][15:8], 0);
        reset = 1'b0;
        tick();
        check_reset_values("midword_reset");
        reset = 1'b1;
        load_program(prog3, 0);
        run_and_check("after_reset");

        // Random programs
        for (int t = 0; t < 8; t++) begin
            int len;
            int kind;
            pulse_reload();
            len = $urandom_range(8, 1);
            words.delete();
            for (int i = 0; i < len; i++) begin
                logic [31:0] w;
                w = $urandom();
                if (w == EBREAK || w == SELF_LOOP) w = 32'h0000_0013;
                words.push_back(w);
            end
            kind = $urandom_range(2, 0);
            if (kind == 0) words[len-1] = EBREAK;
            else if (kind == 1) words[$urandom_range(len-1, 0)] = EBREAK;
            else words[len-1] = SELF_LOOP;
            load_program(words, $urandom_range(3, 0));
            run_and_check($sformatf("rand_%0d", t));
        end

        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
